peripheral_bfm_memory_wb: RTL and testbench

//   Wishbone B3 slave memory: the responder end for peripheral_bfm_transactor_wb in WB testbenches.

---
 rtl/peripheral_wb_pkg.sv | 25 ++
 rtl/peripheral_wb_burst_addr.sv | 36 +++
 rtl/peripheral_bfm_memory_wb.sv | 195 +++++++++++++++++++
 tb/tb_peripheral_bfm_memory_wb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone B3 definitions for the WB BFM slice.
// Holds the cycle-type and burst-type encodings used on the WB bus,
// and the state enumeration of the slave memory responder.
package peripheral_wb_pkg;

  // Cycle type identifiers (wb_cti)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions (wb_bte)
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Slave memory responder states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } wb_state_e;

endpackage

// File: rtl/peripheral_wb_burst_addr.sv
// Next-beat address generator for Wishbone incrementing bursts.
// Ports:
//   adr_i      in  AW  current beat byte address
//   bte_i      in  2   burst type (linear / wrap4 / wrap8 / wrap16)
//   adr_next_o out AW  byte address of the following beat
// The address advances by one word; for wrapping bursts only the bits
// inside the wrap window change, so the burst stays in its aligned block.
module peripheral_wb_burst_addr
  import peripheral_wb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [AW-1:0] adr_next_o
);

  localparam int BYTES = DW / 8;

  logic [AW-1:0] mask;
  logic [AW-1:0] adr_inc;

  // Wrap window mask from burst type, then merge incremented low bits
  always_comb begin
    case (bte_i)
      BTE_WRAP4:  mask = AW'(4 * BYTES - 1);
      BTE_WRAP8:  mask = AW'(8 * BYTES - 1);
      BTE_WRAP16: mask = AW'(16 * BYTES - 1);
      default:    mask = '1;  // linear: every bit may carry
    endcase
    adr_inc    = adr_i + AW'(BYTES);
    adr_next_o = (adr_i & ~mask) | (adr_inc & mask);
  end

endmodule

// File: rtl/peripheral_bfm_memory_wb.sv
// Wishbone B3 slave memory, the responder end for WB master transactors.
// Word-organised RAM with byte-lane writes, classic and incrementing bursts
// (linear, wrap4/8/16), programmable wait states before the first ack, and
// err termination for out-of-range or misaligned beats.
// Ports:
//   wb_clk_i / wb_rst_i        clock, synchronous active-high reset
//   wb_adr_i, wb_dat_i         byte address, write data
//   wb_sel_i, wb_we_i          byte-lane select, write enable
//   wb_cyc_i, wb_stb_i         cycle valid, strobe
//   wb_cti_i, wb_bte_i         cycle type id, burst type
//   wb_dat_o                   read data (valid with wb_ack_o)
//   wb_ack_o, wb_err_o         normal / error termination
//   wb_rty_o                   retry, never asserted
module peripheral_bfm_memory_wb
  import peripheral_wb_pkg::*;
#(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int unsigned MEM_BASE    = 0,
  parameter int unsigned MEM_SIZE    = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int BYTES = DW / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int WORDS = MEM_SIZE / BYTES;
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DW-1:0] mem [WORDS];

  wb_state_e     state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [1:0]    bte_q, bte_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          bad_q, bad_d;
  logic [DW-1:0] dat_q, dat_d;

  logic [AW-1:0] adr_next;
  logic [AW-1:0] look_adr;
  logic          load;
  logic          beat;
  logic          wr_en;

  // True when the byte address is outside the window or not word aligned
  function automatic logic addr_bad(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - AW'(MEM_BASE);
    return (a < AW'(MEM_BASE)) || (off >= AW'(MEM_SIZE)) ||
           ((a & AW'(BYTES - 1)) != '0);
  endfunction

  // Word index of a byte address inside the RAM
  function automatic logic [IDXW-1:0] word_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - AW'(MEM_BASE);
    return IDXW'(off >> LSB);
  endfunction

  peripheral_wb_burst_addr #(.AW(AW), .DW(DW)) u_burst_addr (
    .adr_i      (adr_q),
    .bte_i      (bte_q),
    .adr_next_o (adr_next)
  );

  assign beat  = ack_q & wb_cyc_i & wb_stb_i;
  assign wr_en = beat & ~bad_q & wb_we_i & ~wb_rst_i;

  // Next-state, burst address and prefetch selection
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    bte_d    = bte_q;
    cnt_d    = cnt_q;
    look_adr = adr_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d    = wb_adr_i;
          bte_d    = wb_bte_i;
          look_adr = wb_adr_i;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = ST_ACK;
            load    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wb_stb_i) begin
          // Any non-incrementing beat (classic, const, end-of-burst) or an
          // err closes the cycle; otherwise prefetch the following word.
          if (bad_q || (wb_cti_i != CTI_INC)) begin
            state_d = ST_IDLE;
          end else begin
            adr_d    = adr_next;
            look_adr = adr_next;
            load     = 1'b1;
          end
        end else begin
          state_d = ST_ACK;  // master stall: address frozen
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered response flags and read data
  always_comb begin
    ack_d = (state_d == ST_ACK);
    if (!ack_d) begin
      bad_d = 1'b0;
      dat_d = '0;
    end else if (load) begin
      bad_d = addr_bad(look_adr);
      dat_d = bad_d ? '0 : mem[word_idx(look_adr)];
    end else begin
      bad_d = bad_q;
      dat_d = dat_q;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      bte_q   <= BTE_LINEAR;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      bad_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      bad_q   <= bad_d;
      dat_q   <= dat_d;
    end
  end

  // Byte-lane RAM writes; contents are kept across reset
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wb_sel_i[b]) begin
          mem[word_idx(adr_q)][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o = beat & ~bad_q;
  assign wb_err_o = beat & bad_q;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_peripheral_bfm_memory_wb.sv
// Directed self-checking bench for peripheral_bfm_memory_wb (WAIT_STATES=2).
module tb_peripheral_bfm_memory_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel_i = 4'hF;
  logic        we_i = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = 3'b000;
  logic [1:0]  bte_i = 2'b00;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wdat [16];
  logic [31:0] rdat [16];
  int          resp [16];

  peripheral_bfm_memory_wb #(
    .DW(32), .AW(32), .MEM_BASE(0), .MEM_SIZE(1024), .WAIT_STATES(2)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel_i), .wb_we_i(we_i), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte_i), .wb_dat_o(dat_o), .wb_ack_o(ack_o),
    .wb_err_o(err_o), .wb_rty_o(rty_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single classic cycle; lat = edges from first stb sample to ack sample
  task automatic wb_single(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd,
                           output logic ak, output logic er, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_i = we; adr = a; dat_i = d; sel_i = sel;
    cti = 3'b000; bte_i = 2'b00;
    ak = 1'b0; er = 1'b0; rd = '0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        ak = ack_o; er = err_o; rd = dat_o; lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0; sel_i = 4'hF;
    if (lat < 0) check_eq("single_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic ak, er; int lat;
    wb_single(1'b0, a, 32'd0, 4'hF, rd, ak, er, lat);
    check_eq(tag, rd, exp);
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic ak, er; int lat;
    wb_single(1'b1, a, d, 4'hF, rd, ak, er, lat);
  endtask

  // Incrementing burst; optional stall at a beat and early cyc drop
  task automatic wb_burst(input logic we, input logic [31:0] a0, input logic [1:0] bte,
                          input int n, input int stall_at, input int stall_len,
                          input int abort_at, output int nresp, output int gaps);
    int beat; int stalled; bit done;
    beat = 0; stalled = 0; done = 1'b0; nresp = 0; gaps = 0;
    for (int k = 0; k < 16; k++) begin resp[k] = 0; rdat[k] = '0; end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_i = we; bte_i = bte; sel_i = 4'hF; adr = a0;
    dat_i = wdat[0]; cti = (n == 1) ? 3'b111 : 3'b010;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        resp[beat] = ack_o ? 1 : 2; rdat[beat] = dat_o;
        beat++; nresp++;
        if (err_o || beat == n || beat == abort_at) done = 1'b1;
      end else if (!stb) begin
        check_eq("stall_no_ack", {31'd0, ack_o}, 32'd0);
      end else if (nresp > 0) begin
        gaps++;
      end
      @(posedge clk); #1;
      if (done) begin
        cyc = 1'b0; stb = 1'b0; cti = 3'b000; we_i = 1'b0;
      end else if (beat == stall_at && stalled < stall_len) begin
        stb = 1'b0; stalled++;
      end else begin
        stb = 1'b1; adr = a0 + 32'(4 * beat); dat_i = wdat[beat];
        cti = (beat == n - 1) ? 3'b111 : 3'b010;
      end
    end
    if (!done) check_eq("burst_timeout", 32'd0, 32'd1);
  endtask

  // Start a cycle and reset it either in WAIT or while ack is shown
  task automatic reset_mid(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input bit to_ack);
    bit seen;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_i = we; adr = a; dat_i = d; sel_i = 4'hF; cti = 3'b000;
    seen = 1'b0;
    if (to_ack) begin
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        seen = ack_o;
      end
      if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ack"}, {31'd0, ack_o}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check_eq({tag, "_dat"}, dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic ak, er; int lat; int nresp, gaps;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ack", {31'd0, ack_o}, 32'd0);
    check_eq("rst_err", {31'd0, err_o}, 32'd0);
    check_eq("rst_dat", dat_o, 32'd0);
    check_eq("rty_tied", {31'd0, rty_o}, 32'd0);

    // 1: classic write / read
    wb_single(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, ak, er, lat);
    check_eq("t1_wr_ack", {31'd0, ak}, 32'd1);
    check_eq("t1_wr_lat", lat, 32'd3);
    wb_single(1'b0, 32'h10, 32'd0, 4'hF, rd, ak, er, lat);
    check_eq("t1_rd_ack", {31'd0, ak}, 32'd1);
    check_eq("t1_rd_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("t1_ack_one_cycle", {31'd0, ack_o}, 32'd0);

    // 2: byte-lane write, wait-state latency
    wb_single(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, ak, er, lat);
    check_eq("t2_wr_lat", lat, 32'd3);
    wb_single(1'b0, 32'h10, 32'd0, 4'hF, rd, ak, er, lat);
    check_eq("t2_rd_data", rd, 32'hDEADBEAA);
    check_eq("t2_rd_lat", lat, 32'd3);

    // 3: wrap4 write burst from 0x28
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    wb_burst(1'b1, 32'h28, 2'b01, 4, -1, 0, -1, nresp, gaps);
    check_eq("t3_nresp", nresp, 32'd4);
    check_eq("t3_gaps", gaps, 32'd0);
    rd_word("t3_w20", 32'h20, 32'd3);
    rd_word("t3_w24", 32'h24, 32'd4);
    rd_word("t3_w28", 32'h28, 32'd1);
    rd_word("t3_w2c", 32'h2C, 32'd2);

    // 4: linear fill of 0x3E0..0x3FC, then stalled linear read burst
    for (int i = 0; i < 8; i++) wdat[i] = 32'hA0 + 32'(i);
    wb_burst(1'b1, 32'h3E0, 2'b00, 8, -1, 0, -1, nresp, gaps);
    check_eq("t4_fill_nresp", nresp, 32'd8);
    wb_burst(1'b0, 32'h3E0, 2'b00, 8, 3, 2, -1, nresp, gaps);
    check_eq("t4_rd_nresp", nresp, 32'd8);
    check_eq("t4_rd_gaps", gaps, 32'd0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("t4_rd_beat%0d", i), rdat[i], 32'hA0 + 32'(i));

    // 5: error terminations
    wb_single(1'b0, 32'h400, 32'd0, 4'hF, rd, ak, er, lat);
    check_eq("t5_oor_err", {31'd0, er}, 32'd1);
    check_eq("t5_oor_ack", {31'd0, ak}, 32'd0);
    check_eq("t5_oor_dat", rd, 32'd0);
    wb_single(1'b0, 32'h12, 32'd0, 4'hF, rd, ak, er, lat);
    check_eq("t5_mis_err", {31'd0, er}, 32'd1);
    check_eq("t5_mis_ack", {31'd0, ak}, 32'd0);
    wb_burst(1'b0, 32'h3F8, 2'b00, 4, -1, 0, -1, nresp, gaps);
    check_eq("t5_b_nresp", nresp, 32'd3);
    check_eq("t5_b_resp0", resp[0], 32'd1);
    check_eq("t5_b_resp1", resp[1], 32'd1);
    check_eq("t5_b_resp2", resp[2], 32'd2);
    check_eq("t5_b_dat1", rdat[1], 32'hA7);
    check_eq("t5_b_dat2", rdat[2], 32'd0);
    rd_word("t5_after_err", 32'h3F8, 32'hA6);

    // 6: abort mid-burst, then resets mid-cycle
    wr_word(32'h108, 32'h55555555);
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    wb_burst(1'b1, 32'h100, 2'b00, 4, -1, 0, 2, nresp, gaps);
    check_eq("t6_abort_nresp", nresp, 32'd2);
    rd_word("t6_w100", 32'h100, 32'h11);
    rd_word("t6_w104", 32'h104, 32'h22);
    rd_word("t6_w108_kept", 32'h108, 32'h55555555);
    reset_mid("t6_rst_wait", 1'b0, 32'h10, 32'd0, 1'b0);
    reset_mid("t6_rst_rdack", 1'b0, 32'h10, 32'd0, 1'b1);
    wr_word(32'h200, 32'h12345678);
    reset_mid("t6_rst_wrack", 1'b1, 32'h200, 32'hFFFFFFFF, 1'b1);
    rd_word("t6_no_wr_in_rst", 32'h200, 32'h12345678);
    wb_single(1'b0, 32'h10, 32'd0, 4'hF, rd, ak, er, lat);
    check_eq("t6_post_rst_data", rd, 32'hDEADBEAA);
    check_eq("t6_post_rst_lat", lat, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
